// File: rtl/cc_unit_if.sv
// cc_unit_if: bus/control/status bundle between the datapath, control FSM
// and the condition-code unit. Parameters must match the cc_unit instance.
interface cc_unit_if #(
  parameter int WIDTH       = 16,
  parameter int STACK_DEPTH = 4
);
  localparam int DW = $clog2(STACK_DEPTH + 1);

  // datapath / control inputs to the unit
  logic [WIDTH-1:0] bus;
  logic             ld_cc;
  logic             ld_psr;
  logic [2:0]       psr_cc;
  logic             cc_push;
  logic             cc_pop;
  logic [2:0]       ir_nzp;
  logic             ld_ben;

  // status outputs from the unit
  logic [2:0]       cc;
  logic             ben;
  logic [DW-1:0]    stack_depth;
  logic             stack_full;
  logic             stack_empty;
  logic             stack_err;

  // control path side: drives the enables, observes CC/BEN/stack state
  modport master (
    output bus, ld_cc, ld_psr, psr_cc, cc_push, cc_pop, ir_nzp, ld_ben,
    input  cc, ben, stack_depth, stack_full, stack_empty, stack_err
  );

  // condition-code unit side
  modport slave (
    input  bus, ld_cc, ld_psr, psr_cc, cc_push, cc_pop, ir_nzp, ld_ben,
    output cc, ben, stack_depth, stack_full, stack_empty, stack_err
  );
endinterface

// File: rtl/cc_unit.sv
// cc_unit: LC-3 condition-code register with a LIFO of saved CCs for nested
// interrupt entry/RTI, plus the registered branch-enable bit.
// Optional feature macro: CC_STACK_ERR_EN -- when defined, stack_err is a
// sticky overflow/underflow flag cleared only by reset; otherwise tied low.
module cc_unit #(
  parameter int WIDTH       = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  cc_unit_if.slave   cif
);
  localparam int            DW        = $clog2(STACK_DEPTH + 1);
  localparam logic [DW-1:0] DEPTH_MAX = DW'(STACK_DEPTH);
  localparam logic [2:0]    CC_RST    = 3'b010;

  logic [2:0]    cc_q, cc_nxt;
  logic [2:0]    dec_cc;
  logic [2:0]    top_cc;
  logic          ben_q;
  logic [DW-1:0] depth_q, depth_nxt;
  logic [2:0]    stack_q [STACK_DEPTH];

  logic full, empty;
  logic push_only, pop_only;
  logic push_ok, pop_ok;

  assign full      = (depth_q == DEPTH_MAX);
  assign empty     = (depth_q == '0);
  // a simultaneous push and pop cancel out: no stack change, no error
  assign push_only = cif.cc_push & ~cif.cc_pop;
  assign pop_only  = cif.cc_pop  & ~cif.cc_push;
  assign push_ok   = push_only & ~full;
  assign pop_ok    = pop_only  & ~empty;

  // decode {N,Z,P} from the bus; exactly one bit set
  always_comb begin
    dec_cc[2] = cif.bus[WIDTH-1];
    dec_cc[1] = (cif.bus == '0);
    dec_cc[0] = ~dec_cc[2] & ~dec_cc[1];
  end

  // select stack top (entry[depth-1]); don't-care value when empty
  always_comb begin
    top_cc = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (depth_q == DW'(i + 1)) top_cc = stack_q[i];
    end
  end

  // CC next value: bus load beats PSR load beats pop restore beats hold;
  // a pop under ld_cc/ld_psr still retires its entry but the value is dropped
  always_comb begin
    cc_nxt = cc_q;
    if (cif.ld_cc)       cc_nxt = dec_cc;
    else if (cif.ld_psr) cc_nxt = cif.psr_cc;
    else if (pop_ok)     cc_nxt = top_cc;
  end

  // occupancy update; rejected push/pop leave depth alone
  always_comb begin
    depth_nxt = depth_q;
    if (push_ok)     depth_nxt = depth_q + DW'(1);
    else if (pop_ok) depth_nxt = depth_q - DW'(1);
  end

  // control registers: CC, BEN (sampled from pre-update CC) and depth
  always_ff @(posedge clk) begin
    if (reset) begin
      cc_q    <= CC_RST;
      ben_q   <= 1'b0;
      depth_q <= '0;
    end else begin
      cc_q    <= cc_nxt;
      depth_q <= depth_nxt;
      if (cif.ld_ben) ben_q <= |(cif.ir_nzp & cc_q);
    end
  end

  // stack storage: no reset on the entries, only depth tracks validity;
  // reset still blocks a push landing in the same cycle
  always_ff @(posedge clk) begin
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (!reset && push_ok && depth_q == DW'(i)) stack_q[i] <= cc_q;
    end
  end

`ifdef CC_STACK_ERR_EN
  logic err_q;
  logic overflow, underflow;

  assign overflow  = push_only & full;
  assign underflow = pop_only  & empty;

  // sticky error: any rejected push or pop, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset)                     err_q <= 1'b0;
    else if (overflow | underflow) err_q <= 1'b1;
  end

  assign cif.stack_err = err_q;
`else
  assign cif.stack_err = 1'b0;
`endif

  assign cif.cc          = cc_q;
  assign cif.ben         = ben_q;
  assign cif.stack_depth = depth_q;
  assign cif.stack_full  = full;
  assign cif.stack_empty = empty;

endmodule

// File: tb/tb_cc_unit.sv
// tb_cc_unit: directed test-plan steps followed by randomized traffic, all
// checked against a queue-based reference model of the CC unit.
module tb_cc_unit;
  localparam int WIDTH = 16;
  localparam int SD    = 4;
`ifdef CC_STACK_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk;
  logic reset;

  cc_unit_if #(.WIDTH(WIDTH), .STACK_DEPTH(SD)) cif ();

  cc_unit #(.WIDTH(WIDTH), .STACK_DEPTH(SD)) dut (
    .clk   (clk),
    .reset (reset),
    .cif   (cif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [2:0] m_cc;
  logic       m_ben;
  logic       m_err;
  logic [2:0] m_q [$];

  function automatic logic [2:0] decode(input logic [WIDTH-1:0] b);
    if (b == 0)            return 3'b010;
    else if (b[WIDTH-1])   return 3'b100;
    else                   return 3'b001;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("cc",    32'(cif.cc),          32'(m_cc));
    chk("ben",   32'(cif.ben),         32'(m_ben));
    chk("depth", 32'(cif.stack_depth), 32'(m_q.size()));
    chk("full",  32'(cif.stack_full),  32'(m_q.size() == SD));
    chk("empty", 32'(cif.stack_empty), 32'(m_q.size() == 0));
    chk("err",   32'(cif.stack_err),   32'(ERR_EN & m_err));
  endtask

  // drive one cycle of inputs, advance the model, then compare after the edge
  task automatic step(input logic r, input logic lc, input logic [WIDTH-1:0] b,
                      input logic lp, input logic [2:0] pc, input logic pu,
                      input logic po, input logic [2:0] nzp, input logic lb);
    logic [2:0] old_cc;
    logic [2:0] popped;
    logic       have_pop;
    reset = r; cif.ld_cc = lc; cif.bus = b; cif.ld_psr = lp; cif.psr_cc = pc;
    cif.cc_push = pu; cif.cc_pop = po; cif.ir_nzp = nzp; cif.ld_ben = lb;
    if (r) begin
      m_cc = 3'b010; m_ben = 1'b0; m_err = 1'b0; m_q.delete();
    end else begin
      old_cc   = m_cc;
      have_pop = 1'b0;
      popped   = 3'b000;
      if (lb) m_ben = (nzp & old_cc) != 3'b000;
      if (pu && !po) begin
        if (m_q.size() < SD) m_q.push_back(old_cc);
        else                 m_err = 1'b1;
      end
      if (po && !pu) begin
        if (m_q.size() > 0) begin popped = m_q.pop_back(); have_pop = 1'b1; end
        else                m_err = 1'b1;
      end
      if (lc)            m_cc = decode(b);
      else if (lp)       m_cc = pc;
      else if (have_pop) m_cc = popped;
    end
    @(posedge clk);
    #1;
    chk_all();
    reset = 1'b0; cif.ld_cc = 1'b0; cif.ld_psr = 1'b0; cif.cc_push = 1'b0;
    cif.cc_pop = 1'b0; cif.ld_ben = 1'b0;
  endtask

  task automatic do_rst();              step(1, 0, '0, 0, 3'b0, 0, 0, 3'b0, 0); endtask
  task automatic do_ldcc(input logic [WIDTH-1:0] b); step(0, 1, b, 0, 3'b0, 0, 0, 3'b0, 0); endtask
  task automatic do_push();             step(0, 0, '0, 0, 3'b0, 1, 0, 3'b0, 0); endtask
  task automatic do_pop();              step(0, 0, '0, 0, 3'b0, 0, 1, 3'b0, 0); endtask
  task automatic do_ldben(input logic [2:0] n); step(0, 0, '0, 0, 3'b0, 0, 0, n, 1); endtask

  initial begin
    reset = 1'b0; cif.bus = '0; cif.ld_cc = 1'b0; cif.ld_psr = 1'b0;
    cif.psr_cc = 3'b0; cif.cc_push = 1'b0; cif.cc_pop = 1'b0;
    cif.ir_nzp = 3'b0; cif.ld_ben = 1'b0;
    m_cc = 3'b010; m_ben = 1'b0; m_err = 1'b0;
    @(negedge clk);

    // reset values
    do_rst();
    chk("rst_cc", 32'(cif.cc), 32'h2);
    chk("rst_empty", 32'(cif.stack_empty), 32'h1);

    // bus decode
    do_ldcc(16'h8000); chk("dec_neg",  32'(cif.cc), 32'h4);
    do_ldcc(16'h0000); chk("dec_zero", 32'(cif.cc), 32'h2);
    do_ldcc(16'h7FFF); chk("dec_pos",  32'(cif.cc), 32'h1);

    // BEN uses the pre-update CC
    do_ldben(3'b001);                         chk("ben_p", 32'(cif.ben), 32'h1);
    step(0, 1, 16'h0, 0, 3'b0, 0, 0, 3'b010, 1); chk("ben_old", 32'(cif.ben), 32'h0);
    do_ldben(3'b010);                         chk("ben_z", 32'(cif.ben), 32'h1);

    // stack round trip
    do_ldcc(16'h8000); do_push();
    do_ldcc(16'h0001); do_push();
    do_ldcc(16'h0000);
    do_pop(); chk("pop1_cc", 32'(cif.cc), 32'h1); chk("pop1_d", 32'(cif.stack_depth), 32'h1);
    do_pop(); chk("pop2_cc", 32'(cif.cc), 32'h4); chk("pop2_d", 32'(cif.stack_depth), 32'h0);

    // overflow
    for (int i = 0; i < 5; i++) do_push();
    chk("ovf_full", 32'(cif.stack_full), 32'h1);
    chk("ovf_d", 32'(cif.stack_depth), 32'h4);

    // underflow after reset
    do_rst(); do_pop();
    chk("udf_cc", 32'(cif.cc), 32'h2);
    chk("udf_err", 32'(cif.stack_err), 32'(ERR_EN));

    // simultaneous events
    do_rst(); do_push(); do_push();
    step(0, 0, '0, 0, 3'b0, 1, 1, 3'b0, 0);
    chk("pp_d", 32'(cif.stack_depth), 32'h2);
    step(0, 0, '0, 1, 3'b100, 0, 1, 3'b0, 0);
    chk("psr_pop_cc", 32'(cif.cc), 32'h4);
    chk("psr_pop_d", 32'(cif.stack_depth), 32'h1);

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      logic [WIDTH-1:0] b;
      int sel;
      sel = $urandom_range(0, 3);
      b = (sel == 0) ? '0 : (sel == 1) ? WIDTH'($urandom) | 16'h8000 : WIDTH'($urandom);
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) == 0), b,
           ($urandom_range(0, 4) == 0), 3'($urandom), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 2) == 0), 3'($urandom), ($urandom_range(0, 1) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cc_unit.md
# cc_unit

Parametrised condition-code unit for the LC-3 control path: captures {N,Z,P} from a WIDTH-bit datapath bus, supports direct CC load from the PSR, and keeps a LIFO stack of saved CC values for nested interrupt entry and return. It also registers the branch-enable bit (BEN) from the instruction nzp field against the current CC. Sits between the datapath bus and the control FSM.

## Interface
- WIDTH, 16: datapath bus width; N is bus[WIDTH-1].
- STACK_DEPTH, 4: number of saved CC entries, at least 1.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- bus  in  WIDTH  datapath result.
- ld_cc  in  1  capture CC from bus.
- ld_psr  in  1  load CC directly from psr_cc.
- psr_cc  in  3  {N,Z,P} from the PSR, used on ld_psr.
- cc_push  in  1  push the current CC on interrupt entry.
- cc_pop  in  1  restore CC from the stack top on RTI.
- ir_nzp  in  3  instruction bits [11:9].
- ld_ben  in  1  register BEN.
- cc  out  3  {N,Z,P}.
- ben  out  1  registered branch enable.
- stack_depth  out  $clog2(STACK_DEPTH+1)  occupied entries.
- stack_full  out  1  stack_depth == STACK_DEPTH.
- stack_empty  out  1  stack_depth == 0.
- stack_err  out  1  sticky push-overflow or pop-underflow flag.

## Operation
- Decode from bus: N = bus[WIDTH-1]; Z = (bus == 0); P = ~N & ~Z. Exactly one bit of the decoded value is set.
- CC next-value priority per cycle:
  - ld_cc: decoded bus.
  - else ld_psr: psr_cc, taken verbatim with no one-hot check.
  - else a valid pop without push: stack top.
  - else hold.
- Stack operations:
  - push only, not full: writes the pre-update cc to entry[stack_depth], then depth+1.
  - push only, full: ignored; nothing written; depth unchanged; stack_err set.
  - pop only, not empty: CC candidate is entry[stack_depth-1], then depth-1.
  - pop only, empty: ignored; CC unaffected by the pop; stack_err set.
  - push and pop together: no stack change and no error; CC follows the ld_cc/ld_psr priority, else holds.
- ld_cc or ld_psr together with a valid pop: the pop still decrements depth, but the popped value is discarded.
- BEN: on ld_ben, ben <= |(ir_nzp & cc), using the registered cc (pre-update value in that cycle). Otherwise ben holds.
- Stack entries are not cleared on reset; only depth is reset.

## Timing
- Reset values: cc = 3'b010, ben = 0, stack_depth = 0, stack_empty = 1, stack_full = 0, stack_err = 0.
- Reset overrides all other inputs in the same cycle, including mid push/pop sequences.
- cc, ben, stack_depth and stack_err update on the clk edge after the enable is sampled: latency 1.
- stack_full and stack_empty are combinational from stack_depth.
- BEN uses the CC value visible before the edge. ld_cc and ld_ben in the same cycle therefore give BEN from the old CC, matching the LC-3 FSM where BEN is loaded in decode state 32.
- Back-to-back push/pop every cycle is supported with no bubbles.

## Configuration
- CC_STACK_ERR_EN defined:
  - stack_err is a sticky register, set on overflow or underflow and cleared only by reset.
- CC_STACK_ERR_EN undefined:
  - stack_err is tied to 0 and no error register is built.
  - Overflow and underflow are still ignored exactly as described above.

## Test plan
- Reset: assert reset, then release. Expect cc = 010, ben = 0, depth = 0, empty = 1.
- CC decode (WIDTH=16): ld_cc with bus = 16'h8000 gives cc = 100; bus = 0 gives 010; bus = 16'h7FFF gives 001.
- BEN against old CC: with cc = 001, ld_ben with ir_nzp = 001 gives ben = 1.
  - Then ld_cc with bus = 0 plus ld_ben with ir_nzp = 010 in one cycle gives cc = 010 and ben = 0.
  - Next cycle ld_ben with ir_nzp = 010 gives ben = 1.
- Stack round trip (STACK_DEPTH=4):
  - Set cc = 100, push; set cc = 001, push; set cc = 010.
  - Pop gives cc = 001, depth = 1; second pop gives cc = 100, depth = 0.
- Overflow and underflow:
  - 5 pushes give depth = 4, full = 1, stack_err = 1 (with macro).
  - After reset, pop on empty leaves cc = 010, depth = 0, stack_err = 1 with the macro, stack_err = 0 without.
- Simultaneous events:
  - push and pop in one cycle with depth = 2: depth stays 2 and cc is unchanged.
  - ld_psr with psr_cc = 100 plus a valid pop: cc = 100, depth decremented.
